// File: rtl/vga_sprite_display.sv
// rtl/vga_sprite_display.sv - VGA pixel engine with scrolling background, sprites and collision scoring
module vga_sprite_display #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_SYNC   = 96,
    parameter int V_SYNC   = 2,
    parameter int X_BEFORE = 144,
    parameter int Y_BEFORE = 35,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BG_L     = 640,
    parameter int BG_W     = 480,
    parameter int N_OBJ    = 4,
    parameter int OBJ_SIZE = 40,
    parameter int SCORE_W  = 8
) (
    input  logic                 clk_vga,
    input  logic                 rst_n,
    input  logic                 end_show,
    input  logic [11:0]          x_begin,
    input  logic [12*N_OBJ-1:0]  obj_x,
    input  logic [12*N_OBJ-1:0]  obj_y,
    input  logic [12*N_OBJ-1:0]  obj_color,
    input  logic [15:0]          color_data_in,
    output logic                 addr_ena,
    output logic                 x_valid,
    output logic                 y_valid,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 frame_start,
    output logic [N_OBJ-1:0]     hit,
    output logic [SCORE_W-1:0]   score
);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC12 = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC12 = 12'(V_SYNC);
    localparam logic [12:0] XB13  = 13'(X_BEFORE);
    localparam logic [12:0] YB13  = 13'(Y_BEFORE);
    localparam logic [12:0] HA13  = 13'(H_ACTIVE);
    localparam logic [12:0] VA13  = 13'(V_ACTIVE);
    localparam logic [12:0] BGL13 = 13'(BG_L);
    localparam logic [12:0] BGW13 = 13'(BG_W);
    localparam logic [12:0] OS13  = 13'(OBJ_SIZE);
    localparam logic [SCORE_W+3:0] SCORE_MAX = {4'b0000, {SCORE_W{1'b1}}};

    logic [11:0]        h_cnt, v_cnt;
    logic [12:0]        h13, v13, px, py, xb13;
    logic               active, wrap;
    logic [N_OBJ-1:0]   obj_en;
    logic [11:0]        obj_pick;

    logic               active_d, addr_ena_d, hs_d, vs_d;
    logic [N_OBJ-1:0]   obj_en_d;
    logic [11:0]        obj_col_d;

    logic [11:0]        pix;
    logic [N_OBJ-1:0]   coll;
    logic [N_OBJ-1:0]   hit_acc;
    logic [SCORE_W+3:0] pop, score_sum;
    logic [SCORE_W-1:0] score_next;

    // Free-running pixel/line counters; one frame is H_TOTAL x V_TOTAL clocks
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    assign wrap   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign h13    = {1'b0, h_cnt};
    assign v13    = {1'b0, v_cnt};
    assign px     = h13 - XB13;
    assign py     = v13 - YB13;
    assign xb13   = {1'b0, x_begin};
    assign active = (h13 >= XB13) && (h13 < XB13 + HA13) &&
                    (v13 >= YB13) && (v13 < YB13 + VA13);

    // Background window is bottom-aligned and scrolls horizontally with x_begin
    assign addr_ena = active && (px >= xb13) && (px < xb13 + BGL13) &&
                      (py >= VA13 - BGW13) && (py < VA13);

    // Sprite hit-test at the current position; 13-bit bounds so edges never wrap
    always_comb begin
        obj_en = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            obj_en[i] = active && !end_show &&
                        (px >= {1'b0, obj_x[12*i +: 12]}) &&
                        (px <  {1'b0, obj_x[12*i +: 12]} + OS13) &&
                        (py >= {1'b0, obj_y[12*i +: 12]}) &&
                        (py <  {1'b0, obj_y[12*i +: 12]} + OS13);
        end
    end

    // Lowest-index enabled sprite wins the colour; scan from the top down
    always_comb begin
        obj_pick = 12'h000;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (obj_en[i]) obj_pick = obj_color[12*i +: 12];
        end
    end

    // Stage 1: capture position-derived flags while the RAM read is in flight
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            active_d   <= 1'b0;
            addr_ena_d <= 1'b0;
            obj_en_d   <= '0;
            obj_col_d  <= '0;
            hs_d       <= 1'b1;
            vs_d       <= 1'b1;
        end else begin
            active_d   <= active;
            addr_ena_d <= addr_ena;
            obj_en_d   <= obj_en;
            obj_col_d  <= obj_pick;
            hs_d       <= (h_cnt >= H_SYNC12);
            vs_d       <= (v_cnt >= V_SYNC12);
        end
    end

    // Stage 2 colour select: sprite, then background RGB565 top bits, then border fill
    always_comb begin
        pix = 12'h000;
        if (|obj_en_d)
            pix = obj_col_d;
        else if (addr_ena_d)
            pix = {color_data_in[15:12], color_data_in[10:7], color_data_in[4:1]};
        else if (active_d)
            pix = 12'hFCD;
    end

    assign coll = obj_en_d & {N_OBJ{addr_ena_d && (color_data_in != 16'h0000)}};

    // Stage 2 output registers; syncs travel alongside RGB
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            x_valid <= 1'b1;
            y_valid <= 1'b1;
        end else begin
            red     <= pix[11:8];
            green   <= pix[7:4];
            blue    <= pix[3:0];
            x_valid <= hs_d;
            y_valid <= vs_d;
        end
    end

    // Number of sprites that collided during the frame just ending
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            pop = pop + {{(SCORE_W+3){1'b0}}, hit_acc[i]};
        end
    end

    assign score_sum  = {4'b0000, score} + pop;
    assign score_next = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];

    // Frame boundary: publish sticky collisions, clear the accumulator, add to score
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            hit         <= '0;
            hit_acc     <= '0;
            score       <= '0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                hit     <= hit_acc;
                hit_acc <= '0;
                if (!end_show) score <= score_next;
            end else begin
                hit_acc <= hit_acc | coll;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_display.sv
// tb/tb_vga_sprite_display.sv - randomized self-checking bench for vga_sprite_display
module tb_vga_sprite_display;

    localparam int HT = 40, VT = 30, HS = 4, VS = 2, XB = 8, YB = 4;
    localparam int HA = 28, VA = 24, BL = 20, BW = 16, NO = 4, OS = 6, SW = 2;
    localparam int FR = HT * VT;

    logic              clk_vga = 1'b0;
    logic              rst_n = 1'b0;
    logic              end_show = 1'b0;
    logic [11:0]       x_begin = '0;
    logic [12*NO-1:0]  obj_x = '0, obj_y = '0, obj_color = '0;
    logic [15:0]       color_data_in = '0;
    logic              addr_ena, x_valid, y_valid, frame_start;
    logic [3:0]        red, green, blue;
    logic [NO-1:0]     hit;
    logic [SW-1:0]     score;

    vga_sprite_display #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS), .X_BEFORE(XB), .Y_BEFORE(YB),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .BG_L(BL), .BG_W(BW), .N_OBJ(NO), .OBJ_SIZE(OS), .SCORE_W(SW)
    ) dut (
        .clk_vga(clk_vga), .rst_n(rst_n), .end_show(end_show), .x_begin(x_begin),
        .obj_x(obj_x), .obj_y(obj_y), .obj_color(obj_color), .color_data_in(color_data_in),
        .addr_ena(addr_ena), .x_valid(x_valid), .y_valid(y_valid),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start),
        .hit(hit), .score(score)
    );

    always #5 clk_vga = ~clk_vga;

    int errors = 0;
    int checks = 0;
    int k = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Stimulus knobs
    int          sx[NO], sy[NO];
    logic [11:0] sc[NO];
    int          xb;
    logic        es;
    int          cd_mode;
    logic [15:0] cd_fixed;

    // Reference model state
    typedef struct { logic [11:0] rgb; logic hs; logic vs; } rec_t;
    rec_t        q[$];
    logic [NO-1:0] acc_m, hit_m;
    int          score_m;
    logic        es_prev;
    int          p_h, p_v;
    logic        p_act, p_bg;
    logic [NO-1:0] p_en;
    logic [11:0] p_col;

    task automatic drive_inputs();
        for (int i = 0; i < NO; i++) begin
            obj_x[12*i +: 12]     = 12'(sx[i]);
            obj_y[12*i +: 12]     = 12'(sy[i]);
            obj_color[12*i +: 12] = sc[i];
        end
        x_begin  = 12'(xb);
        end_show = es;
    endtask

    task automatic model_init();
        rec_t r;
        r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
        k = 0;
        q.delete();
        q.push_back(r);
        acc_m = '0; hit_m = '0; score_m = 0; es_prev = es;
    endtask

    // One pixel clock: drive, update the model, then compare on the falling edge
    task automatic step();
        int h, v, px, py, s;
        logic [15:0] cd;
        rec_t r;
        h = k % HT;
        v = (k / HT) % VT;
        drive_inputs();
        cd = (cd_mode == 0) ? cd_fixed : (($urandom % 3 == 0) ? 16'h0000 : 16'($urandom));
        color_data_in = cd;
        if (k > 0 && h == 0 && v == 0) begin
            hit_m = acc_m;
            if (!es_prev) begin
                s = score_m + $countones(acc_m);
                score_m = (s > (1 << SW) - 1) ? (1 << SW) - 1 : s;
            end
            acc_m = '0;
        end
        if (k == 0) begin
            r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
        end else begin
            r.hs = (p_h >= HS);
            r.vs = (p_v >= VS);
            if (p_en != 0)  r.rgb = p_col;
            else if (p_bg)  r.rgb = {cd[15:12], cd[10:7], cd[4:1]};
            else if (p_act) r.rgb = 12'hFCD;
            else            r.rgb = 12'h000;
            for (int i = 0; i < NO; i++)
                if (p_en[i] && p_bg && cd != 16'h0000) acc_m[i] = 1'b1;
        end
        q.push_back(r);
        px = h - XB;
        py = v - YB;
        p_h = h; p_v = v;
        p_act = (h >= XB) && (h < XB + HA) && (v >= YB) && (v < YB + VA);
        p_bg  = p_act && (px >= xb) && (px < xb + BL) && (py >= VA - BW) && (py < VA);
        p_col = 12'h000;
        for (int i = NO - 1; i >= 0; i--) begin
            p_en[i] = p_act && !es && (px >= sx[i]) && (px < sx[i] + OS) &&
                      (py >= sy[i]) && (py < sy[i] + OS);
            if (p_en[i]) p_col = sc[i];
        end
        @(negedge clk_vga);
        r = q.pop_front();
        check("rgb", 32'({red, green, blue}), 32'(r.rgb));
        check("hsync", 32'(x_valid), 32'(r.hs));
        check("vsync", 32'(y_valid), 32'(r.vs));
        check("addr_ena", 32'(addr_ena), 32'(p_bg));
        check("frame_start", 32'(frame_start), 32'(k > 0 && h == 0 && v == 0));
        check("hit", 32'(hit), 32'(hit_m));
        check("score", 32'(score), 32'(score_m));
        es_prev = es;
        @(posedge clk_vga);
        #1;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'h0);
        check({tag, "_xv"}, 32'(x_valid), 32'h1);
        check({tag, "_yv"}, 32'(y_valid), 32'h1);
        check({tag, "_fs"}, 32'(frame_start), 32'h0);
        check({tag, "_hit"}, 32'(hit), 32'h0);
        check({tag, "_score"}, 32'(score), 32'h0);
    endtask

    task automatic overlap_sprites();
        for (int i = 0; i < NO; i++) begin sx[i] = 4000; sy[i] = 4000; sc[i] = 12'h000; end
        sx[0] = 5; sy[0] = 10; sc[0] = 12'h0F0;
        sx[1] = 8; sy[1] = 12; sc[1] = 12'hF00;
    endtask

    initial begin
        for (int i = 0; i < NO; i++) begin sx[i] = 4000; sy[i] = 4000; sc[i] = 12'h000; end
        xb = 0; es = 1'b0; cd_mode = 0; cd_fixed = 16'hFFFF;
        drive_inputs();
        repeat (3) @(posedge clk_vga);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        model_init();

        // Full background, no sprites
        run(FR);

        // Overlapping sprites over black background: drawn, no collision
        overlap_sprites();
        cd_fixed = 16'h0000;
        run(FR);

        // Non-black background: both sprites collide every frame, score saturates
        cd_fixed = 16'h8410;
        run(3 * FR);

        // Randomized geometry, colours, scroll, per-pixel background data
        cd_mode = 1;
        repeat (8) begin
            for (int i = 0; i < NO; i++) begin
                sx[i] = ($urandom % 5 == 0) ? 4000 : int'($urandom_range(0, 35));
                sy[i] = int'($urandom_range(0, 30));
                sc[i] = 12'($urandom);
            end
            xb = int'($urandom_range(0, 20));
            es = ($urandom % 4 == 0);
            run(FR);
        end

        // Asynchronous reset pulsed mid-line
        run(HT * 3 + 17);
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        repeat (3) @(posedge clk_vga);
        #1;
        es = 1'b0; xb = 0; cd_mode = 0; cd_fixed = 16'h8410;
        overlap_sprites();
        rst_n = 1'b1;
        model_init();
        run(FR);

        // end_show raised mid-line inside the overlap: sprites vanish, score frozen
        run(HT * (YB + 13) + XB + 10);
        es = 1'b1;
        run(FR - (HT * (YB + 13) + XB + 10));
        run(FR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sprite_display.md
# vga_sprite_display

Next-generation VGA pixel engine: owns its own 800x525 timing counters, composites a scrolling RAM-backed background with N_OBJ solid-colour square sprites, and detects sprite/background collisions per frame to drive a saturating score. It sits between the background frame RAM (one-cycle read latency) and the VGA connector; game logic supplies sprite positions and reads back per-frame collision flags and score.

## Interface
- H_TOTAL, 800: pixel clocks per line
- V_TOTAL, 525: lines per frame
- H_SYNC, 96: hsync pulse width (clocks)
- V_SYNC, 2: vsync pulse width (lines)
- X_BEFORE, 144: first active h_cnt
- Y_BEFORE, 35: first active v_cnt
- H_ACTIVE, 640 / V_ACTIVE, 480: active area
- BG_L, 640 / BG_W, 480: background window size; window is bottom-aligned
- N_OBJ, 4: sprite channels (1..8)
- OBJ_SIZE, 40: sprite edge length (pixels)
- SCORE_W, 8: score width
- clk_vga  in  1  pixel clock, 25.175 MHz
- rst_n  in  1  asynchronous, active-low reset
- end_show  in  1  game over: sprites hidden, scoring frozen
- x_begin  in  12  background window left edge (active-area pixels)
- obj_x  in  12*N_OBJ  sprite i left edge at [12i+11:12i]
- obj_y  in  12*N_OBJ  sprite i top edge
- obj_color  in  12*N_OBJ  sprite i colour {R,G,B} 4 bits each
- color_data_in  in  16  RGB565 from background RAM, valid 1 cycle after addr_ena
- addr_ena  out  1  background RAM read enable for current counter position
- x_valid  out  1  hsync, active-low
- y_valid  out  1  vsync, active-low
- red, green, blue  out  4 each  registered pixel colour
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- hit  out  N_OBJ  collision flags of the last completed frame
- score  out  SCORE_W  saturating collision count

## Operation
- h_cnt 0..H_TOTAL-1; on wrap v_cnt increments, wraps at V_TOTAL-1 to 0.
- px = h_cnt - X_BEFORE, py = v_cnt - Y_BEFORE; active when h_cnt in [X_BEFORE, X_BEFORE+H_ACTIVE) and v_cnt in [Y_BEFORE, Y_BEFORE+V_ACTIVE).
- addr_ena (combinational from counters) = active && px in [x_begin, x_begin+BG_L) && py in [V_ACTIVE-BG_W, V_ACTIVE).
- obj_en[i] = active && !end_show && px in [obj_x_i, obj_x_i+OBJ_SIZE) && py in [obj_y_i, obj_y_i+OBJ_SIZE). Bounds computed in 13 bits; no wrap. Sprites off-screen are simply not drawn; partial sprites clip to active area.
- Stage 1 register: active, obj_en vector, addr_ena, syncs.
- Stage 2 colour select, priority order: lowest-index enabled sprite -> obj_color_i; else addr_ena_d -> {cd[15:12], cd[10:7], cd[4:1]}; else active -> F,C,D; else 0,0,0.
- Collision: in stage 2, obj_en_d[i] && addr_ena_d && color_data_in != 16'h0000 sets hit_acc[i] (sticky). All overlapping sprites flag independently, regardless of draw priority.
- At frame_start: hit <= hit_acc; hit_acc cleared; if !end_show, score <= min(score + popcount(hit_acc), 2^SCORE_W-1). Collision on same cycle as frame_start is impossible (blanking).
- end_show asserted mid-frame: sprites vanish from the next pixel; already-latched hit_acc still transfers to hit but does not score.

## Timing
- Reset (async assert, sync-free): h_cnt=v_cnt=0, red/green/blue=0, x_valid=y_valid=1, frame_start=0, hit=0, hit_acc=0, score=0, pipeline regs 0.
- x_valid low for h_cnt in [0,H_SYNC), y_valid low for v_cnt in [0,V_SYNC), both delayed 2 cycles to align with RGB.
- RGB latency: 2 clk_vga cycles from counter position to output.
- frame_start, hit, score update at counter (0,0), not delayed.
- Inputs obj_x/obj_y/x_begin sampled every pixel; game logic should change them only during vertical blanking to avoid tearing.

## Test plan
- Reset then free-run: hsync period 800 clks, low 96; vsync period 420000 clks, low 1600; frame_start once per frame; RGB 0 during blanking.
- x_begin=0, color_data_in=16'hFFFF constant, no sprites: active pixels output F,F,F (note bit extraction), addr_ena high for full active area, hit=0, score=0.
- Sprite 0 at (100,100) colour 12'h0F0, sprite 1 at (120,120) colour 12'hF00, color_data_in=0: pixel (125,125) is 0,F,0; hit stays 0.
- Same with color_data_in=16'h8410: next frame_start -> hit=2'b11, score=2; repeated each frame; with SCORE_W=2 score saturates at 3.
- end_show asserted mid-frame during overlap: sprites disappear from next pixel, score unchanged at following frame_start.
- rst_n pulsed low mid-line: outputs go to reset values immediately, counting restarts from (0,0) after release.
